aes_key_expand: RTL



---
 rtl/aes_key_expand.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128/256 round-key generator: one round key per step, forward or inverse.
// Build with AES_KEY_EXPAND_INV_EN defined to include the inverse (decryption-order) datapath.
module aes_sbox #(
  parameter string SBoxImpl = "lut"
) (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) (and maps 0 to 0), then the affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  if (SBoxImpl == "lut") begin : g_lut
    localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    // entry 0 sits in the top byte of the table
    assign data_o = SBOX[{~data_i, 3'b111} -: 8];
  end else begin : g_calc
    assign data_o = sbox_calc(data_i);
  end

endmodule

module aes_key_expand #(
  parameter string SBoxImpl = "lut"
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         op_i,
  input  logic [2:0]   key_len_i,
  input  logic [255:0] key_i,
  input  logic         step_i,
  output logic [127:0] round_key_o,
  output logic [255:0] key_o,
  output logic [3:0]   round_o,
  output logic         done_o
);

  logic [255:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         phase_q, len_q, done_q, inv, use_rot;
  logic [3:0]   round_q, nr;
  logic [31:0]  w [8];
  logic [31:0]  sbox_in, sbox_out, temp, n0, n1, n2, n3;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES_KEY_EXPAND_INV_EN
  logic        op_q;
  logic [31:0] p0, p1, p2, p3;
  assign inv = op_q;

  function automatic logic [7:0] div2(input logic [7:0] x);
    return x[0] ? ({1'b1, x[7:1]} ^ 8'h0d) : {1'b0, x[7:1]};
  endfunction
`else
  logic unused_op;
  assign unused_op = op_i;
  assign inv       = 1'b0;
`endif

  assign nr = len_q ? 4'd14 : 4'd10;

  always_comb begin
    for (int k = 0; k < 8; k++) w[k] = key_q[32*k +: 32];
    // 256-bit schedule alternates Rot+rcon and SubWord-only; inverse runs the phases mirrored
    use_rot = !len_q || (phase_q == inv);
    sbox_in = len_q ? w[7] : w[3];
`ifdef AES_KEY_EXPAND_INV_EN
    if (inv) sbox_in = len_q ? w[3] : (w[3] ^ w[2]);
`endif
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox #(.SBoxImpl(SBoxImpl)) u_sbox (
      .data_i(sbox_in[8*b +: 8]),
      .data_o(sbox_out[8*b +: 8])
    );
  end

  // SubWord commutes with RotWord, so rotate after the S-boxes
  assign temp = use_rot ? ({sbox_out[7:0], sbox_out[31:8]} ^ {24'h0, rcon_q}) : sbox_out;

  always_comb begin
    n0 = w[0] ^ temp;
    n1 = w[1] ^ n0;
    n2 = w[2] ^ n1;
    n3 = w[3] ^ n2;
    key_d  = len_q ? {n3, n2, n1, n0, w[7], w[6], w[5], w[4]}
                   : {w[7], w[6], w[5], w[4], n3, n2, n1, n0};
    rcon_d = use_rot ? xtime(rcon_q) : rcon_q;
`ifdef AES_KEY_EXPAND_INV_EN
    p1 = len_q ? (w[5] ^ w[4]) : (w[1] ^ w[0]);
    p2 = len_q ? (w[6] ^ w[5]) : (w[2] ^ w[1]);
    p3 = len_q ? (w[7] ^ w[6]) : (w[3] ^ w[2]);
    p0 = (len_q ? w[4] : w[0]) ^ temp;
    if (inv) begin
      key_d  = len_q ? {w[3], w[2], w[1], w[0], p3, p2, p1, p0}
                     : {w[7], w[6], w[5], w[4], p3, p2, p1, p0};
      rcon_d = use_rot ? div2(rcon_q) : rcon_q;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      key_q   <= '0;
      rcon_q  <= 8'h01;
      phase_q <= 1'b0;
      round_q <= '0;
      done_q  <= 1'b0;
      len_q   <= 1'b0;
`ifdef AES_KEY_EXPAND_INV_EN
      op_q    <= 1'b0;
`endif
    end else if (clear_i) begin
      key_q   <= '0;
      rcon_q  <= 8'h01;
      phase_q <= 1'b0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else if (load_i) begin
      key_q   <= key_i;
      phase_q <= 1'b0;
      round_q <= '0;
      done_q  <= 1'b0;
      len_q   <= (key_len_i == 3'b100);
`ifdef AES_KEY_EXPAND_INV_EN
      op_q    <= op_i;
      rcon_q  <= !op_i ? 8'h01 : ((key_len_i == 3'b100) ? 8'h40 : 8'h36);
`else
      rcon_q  <= 8'h01;
`endif
    end else if (step_i && !done_q) begin
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      phase_q <= len_q & ~phase_q;
      round_q <= round_q + 4'd1;
      done_q  <= (round_q + 4'd1 == nr);
    end
  end

  assign round_key_o = key_q[127:0];
  assign key_o       = key_q;
  assign round_o     = round_q;
  assign done_o      = done_q;

endmodule
